// File: rtl/mem_readback_if.sv
// Output stream of the memory readback engine: one word per handshake,
// tagged with its source address and an end-of-sweep marker.
interface mem_readback_if #(
  parameter int WID = 5
);
  logic           valid;
  logic           ready;
  logic [WID-1:0] data;
  logic [31:0]    addr;
  logic           last;

  modport master (
    output valid,
    output data,
    output addr,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  addr,
    input  last,
    output ready
  );
endinterface

// File: rtl/mem_readback.sv
// Memory readback engine: walks the read port of a synchronous RAM from
// address 0 to DEPTH_MEM-1 and streams each word out through a small FIFO.
// A read issued in cycle n returns its data in cycle n+2. Two tag bits follow
// each read through that pipe. New reads are issued only when the FIFO is
// guaranteed to have room for every outstanding word, so backpressure never
// loses or repeats data.
module mem_readback #(
  parameter int WID_MEM    = 5,
  parameter int DEPTH_MEM  = 2048,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] rdata,
  mem_readback_if.master     m,
  output logic               busy,
  output logic               done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_MEM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [31:0]        raddr_r;
  logic               v1_r;          // raddr_r holds a live read this cycle
  logic               v2_r;          // rdata holds a live word this cycle
  logic [31:0]        a2_r;          // address of the word on rdata
  logic [WID_MEM-1:0] fifo_data_r [FIFO_DEPTH];
  logic [31:0]        fifo_addr_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [PW-1:0]      wr_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;
  logic               room_s;

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // FIFO occupancy bookkeeping and the issue-credit check.
  always_comb begin
    push_s = v2_r;
    pop_s  = (count_r != {CW{1'b0}}) && m.ready;
    room_s = ({2'b00, count_r} + {{(CW + 1){1'b0}}, v1_r} + {{(CW + 1){1'b0}}, v2_r})
             < (CW + 2)'(FIFO_DEPTH);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Sweep sequencing: next state and read-issue decision; abort wins over everything.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            issue_s     = 1'b1;
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (room_s) begin
            issue_s = 1'b1;
            if (raddr_r + 32'd1 == LAST_ADDR) begin
              state_nxt_s = DRAIN;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        DRAIN: begin
          if (!v1_r && !v2_r && (count_nxt_s == {CW{1'b0}})) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        DONE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, status flags, read address and the two-stage in-flight tag pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      raddr_r <= 32'd0;
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      a2_r    <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      if (issue_s) begin
        raddr_r <= (state_r == IDLE) ? 32'd0 : raddr_r + 32'd1;
      end
      if (abort) begin
        v1_r <= 1'b0;
        v2_r <= 1'b0;
      end else begin
        v1_r <= issue_s;
        v2_r <= v1_r;
      end
      a2_r <= raddr_r;
    end
  end

  // Output FIFO: captures returning words, pops on handshake, flushes on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= {WID_MEM{1'b0}};
        fifo_addr_r[i] <= 32'd0;
      end
      fifo_last_r <= {FIFO_DEPTH{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
    end else if (abort) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= rdata;
        fifo_addr_r[wr_ptr_r] <= a2_r;
        fifo_last_r[wr_ptr_r] <= (a2_r == LAST_ADDR);
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  assign raddr   = raddr_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign m.valid = (count_r != {CW{1'b0}});
  assign m.data  = fifo_data_r[rd_ptr_r];
  assign m.addr  = fifo_addr_r[rd_ptr_r];
  assign m.last  = fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_mem_readback.sv
// Bench for mem_readback: a 16-word synchronous RAM model, directed sweeps,
// and a scoreboard monitor that checks every accepted word in order.
module tb_mem_readback;

  localparam int W = 5;
  localparam int D = 16;
  localparam int F = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [31:0]   raddr;
  logic [W-1:0]  rdata;
  logic          busy;
  logic          done;
  logic [W-1:0]  ram [D];

  mem_readback_if #(.WID(W)) m_if ();

  mem_readback #(.WID_MEM(W), .DEPTH_MEM(D), .FIFO_DEPTH(F)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .raddr (raddr),
    .rdata (rdata),
    .m     (m_if),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [31:0]  addr;
    logic         last;
    int           rel;   // expected handshake cycle after start, -1 = any
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          max_cnt = 0;
  logic [31:0] raddr_at [64];
  logic        busy_at  [64];
  logic        done_at  [64];
  logic        valid_at [64];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: dout registered one cycle after raddr.
  initial rdata = '0;
  always @(posedge clk) rdata <= ram[raddr[3:0]];

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t        e;
    int          rel;
    logic        prev_stall;
    logic [37:0] held;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      rel = cyc - start_cyc;
      if (rel >= 0 && rel < 64) begin
        raddr_at[rel] = raddr;
        busy_at[rel]  = busy;
        done_at[rel]  = done;
        valid_at[rel] = m_if.valid;
      end
      if (int'(dut.count_r) > max_cnt) max_cnt = int'(dut.count_r);
      if (done) done_cnt++;
      if (reset && prev_stall)
        check("stall_hold", {m_if.valid, m_if.last, m_if.addr, m_if.data}, {1'b1, held});
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", {32'd0, m_if.addr}, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("hs_data", 64'(m_if.data), 64'(e.data));
          check("hs_addr", 64'(m_if.addr), 64'(e.addr));
          check("hs_last", 64'(m_if.last), 64'(e.last));
          if (e.rel >= 0) check("hs_cycle", 64'(rel), 64'(e.rel));
        end
      end
      prev_stall = reset && m_if.valid && !m_if.ready;
      held = {m_if.last, m_if.addr, m_if.data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < D; i++)
      ram[i] = (pat == 0) ? 5'(i) : 5'(i * 3 + 7);
  endtask

  task automatic push_exp(input int first, input int last_i, input bit timed);
    exp_t e;
    for (int i = first; i <= last_i; i++) begin
      e.data = ram[i];
      e.addr = 32'(i);
      e.last = (i == D - 1);
      e.rel  = timed ? i + 3 : -1;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic rdy(input int mode, input int r);
    case (mode)
      1:       return (r % 2 == 0);
      2:       return (r >= 12);
      default: return 1'b1;
    endcase
  endfunction

  // Start a sweep at the current cycle and run it until busy drops or stop_rel.
  task automatic sweep(input int mode, input int abort_rel, input int again_rel, input int stop_rel);
    bit fin;
    fin = 1'b0;
    start = 1'b1;
    start_cyc = cyc;
    m_ready_drive(rdy(mode, 0));
    for (int r = 0; r < 120 && !fin; r++) begin
      if (r > 0) begin
        tick();
        start = (r == again_rel);
        abort = (r == abort_rel);
        m_ready_drive(rdy(mode, r));
      end
      @(negedge clk);
      if ((r > 0 && !busy) || r == stop_rel) fin = 1'b1;
    end
    if (!fin) check("sweep_timeout", 64'd0, 64'd1);
  endtask

  task automatic m_ready_drive(input logic v);
    m_if.ready = v;
  endtask

  initial begin : stim
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    m_if.ready = 1'b1;
    fill(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_raddr", 64'(raddr), 64'd0);
    check("rst_valid", 64'(m_if.valid), 64'd0);
    check("rst_data",  64'(m_if.data), 64'd0);
    check("rst_addr",  64'(m_if.addr), 64'd0);
    check("rst_last",  64'(m_if.last), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // 1: full-rate sweep with exact latencies
    fill(0);
    push_exp(0, D - 1, 1'b1);
    sweep(0, -1, -1, -1);
    check("t1_raddr_c1", 64'(raddr_at[1]), 64'd0);
    check("t1_busy_c1",  64'(busy_at[1]), 64'd1);
    check("t1_valid_c2", 64'(valid_at[2]), 64'd0);
    check("t1_valid_c3", 64'(valid_at[3]), 64'd1);
    check("t1_done_c18", 64'(done_at[18]), 64'd0);
    check("t1_done_c19", 64'(done_at[19]), 64'd1);
    check("t1_busy_c19", 64'(busy_at[19]), 64'd1);
    check("t1_busy_c20", 64'(busy_at[20]), 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_q_empty",  64'(exp_q.size()), 64'd0);

    // 2: alternating ready
    tick();
    fill(1);
    push_exp(0, D - 1, 1'b0);
    sweep(1, -1, -1, -1);
    check("t2_q_empty",  64'(exp_q.size()), 64'd0);
    check("t2_done_cnt", 64'(done_cnt), 64'd2);
    check("t2_fifo_max", 64'(max_cnt <= F), 64'd1);

    // 3: long initial stall throttles issue at 4 outstanding reads
    tick();
    fill(1);
    push_exp(0, D - 1, 1'b0);
    sweep(2, -1, -1, -1);
    check("t3_raddr_c4",  64'(raddr_at[4]), 64'd3);
    check("t3_raddr_c8",  64'(raddr_at[8]), 64'd3);
    check("t3_raddr_c12", 64'(raddr_at[12]), 64'd3);
    check("t3_fifo_max",  64'(max_cnt), 64'(F));
    check("t3_q_empty",   64'(exp_q.size()), 64'd0);
    check("t3_done_cnt",  64'(done_cnt), 64'd3);

    // 4: abort on the handshake of address 7, then a fresh sweep
    tick();
    fill(0);
    push_exp(0, 7, 1'b1);
    sweep(0, 10, -1, -1);
    check("t4_valid_c10", 64'(valid_at[10]), 64'd1);
    check("t4_valid_c11", 64'(valid_at[11]), 64'd0);
    check("t4_busy_c11",  64'(busy_at[11]), 64'd0);
    repeat (4) tick();
    @(negedge clk);
    check("t4_valid_late", 64'(m_if.valid), 64'd0);
    check("t4_no_done",    64'(done_cnt), 64'd3);
    check("t4_q_empty",    64'(exp_q.size()), 64'd0);
    tick();
    push_exp(0, D - 1, 1'b1);
    sweep(0, -1, -1, -1);
    check("t4_restart_done", 64'(done_cnt), 64'd4);
    check("t4_restart_q",    64'(exp_q.size()), 64'd0);

    // 5: asynchronous reset between edges mid-sweep
    tick();
    fill(0);
    push_exp(0, 4, 1'b1);
    sweep(0, -1, -1, 7);
    check("t5_valid_c7", 64'(valid_at[7]), 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t5_raddr", 64'(raddr), 64'd0);
    check("t5_valid", 64'(m_if.valid), 64'd0);
    check("t5_data",  64'(m_if.data), 64'd0);
    check("t5_addr",  64'(m_if.addr), 64'd0);
    check("t5_last",  64'(m_if.last), 64'd0);
    check("t5_busy",  64'(busy), 64'd0);
    check("t5_done",  64'(done), 64'd0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("t5_idle_busy",  64'(busy), 64'd0);
    check("t5_idle_valid", 64'(m_if.valid), 64'd0);
    check("t5_idle_raddr", 64'(raddr), 64'd0);
    check("t5_q_empty",    64'(exp_q.size()), 64'd0);

    // 6: start during a sweep, then start+abort together while idle
    tick();
    fill(0);
    push_exp(0, D - 1, 1'b1);
    sweep(0, -1, 6, -1);
    check("t6_done_cnt", 64'(done_cnt), 64'd5);
    check("t6_done_c19", 64'(done_at[19]), 64'd1);
    check("t6_busy_c20", 64'(busy_at[20]), 64'd0);
    check("t6_q_empty",  64'(exp_q.size()), 64'd0);
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("t6_sa_busy",  64'(busy), 64'd0);
    check("t6_sa_valid", 64'(m_if.valid), 64'd0);
    check("t6_sa_raddr", 64'(raddr), 64'd15);
    repeat (3) tick();
    @(negedge clk);
    check("t6_sa_busy2", 64'(busy), 64'd0);
    check("t6_sa_done",  64'(done_cnt), 64'd5);
    check("fifo_bound",  64'(max_cnt <= F), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
